// File: rtl/seg_display_ctrl_pkg.sv
// Shared register map, segment constants and scan state type for the 7-segment display controller.
// Offsets match the Minisys I/O bus decode (base 0xFFFFFC00) used by the keypad scanner.
package seg_display_ctrl_pkg;

    localparam logic [2:0] DISP_DATA_LO = 3'b000;
    localparam logic [2:0] DISP_DATA_HI = 3'b010;
    localparam logic [2:0] DISP_CTRL    = 3'b100;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } scan_state_e;

    // Active-low anode select for one digit
    function automatic logic [7:0] digit_onehot_low(input logic [2:0] idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Minisys I/O bus slice seen by the display controller: strobes, offset, write data, read-back.
// The CPU side is the master; the controller is the slave and returns a registered read value.
interface seg_display_ctrl_if;
    logic        displayCtrl;
    logic        write_enable;
    logic        read_enable;
    logic [2:0]  address;
    logic [15:0] write_data_input;
    logic [15:0] read_data_output;

    modport master (
        output displayCtrl, write_enable, read_enable, address, write_data_input,
        input  read_data_output
    );

    modport slave (
        input  displayCtrl, write_enable, read_enable, address, write_data_input,
        output read_data_output
    );
endinterface

// File: rtl/seg_display_ctrl_decode.sv
// Hex nibble to 7-segment pattern {g,f,e,d,c,b,a}, active-high; purely combinational.
module seg7_decode (
    input  logic [3:0] hex,
    output logic [6:0] pat
);
    always_comb begin
        pat = 7'h00;
        case (hex)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            4'hF: pat = 7'h71;
            default: pat = 7'h00;
        endcase
    end
endmodule

// File: rtl/seg_display_ctrl.sv
// 8-digit multiplexed 7-segment controller with DATA_LO/DATA_HI/CTRL registers on the I/O bus.
// seg/digit_sel and read-back are registered (1-cycle latency); the bus never stalls.
module seg_display_ctrl
    import seg_display_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                clock,
    input  logic                reset,
    seg_display_ctrl_if.slave   bus,
    output logic [7:0]          seg,
    output logic [7:0]          digit_sel
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [15:0]  lo_q, lo_d, hi_q, hi_d, rd_q, rd_d;
    logic [7:0]   en_q, en_d, dp_q, dp_d;
    logic [7:0]   seg_q, seg_d, dsel_q, dsel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]   idx_q, idx_d;
    scan_state_e  state_q, state_d;

    logic [31:0] digits;
    logic [3:0]  nibble;
    logic [6:0]  pat;
    logic        wr_en, rd_en;

    assign digits = {hi_q, lo_q};
    assign nibble = digits[{idx_q, 2'b00} +: 4];
    assign wr_en  = bus.displayCtrl & bus.write_enable;
    assign rd_en  = bus.displayCtrl & bus.read_enable;

    seg7_decode u_decode (
        .hex (nibble),
        .pat (pat)
    );

    always_comb begin
        lo_d    = lo_q;
        hi_d    = hi_q;
        en_d    = en_q;
        dp_d    = dp_q;
        rd_d    = 16'h0000;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        state_d = state_q;
        seg_d   = SEG_OFF;
        dsel_d  = digit_onehot_low(idx_q);

        // Read mux sees pre-write values, so a same-cycle read+write returns the old contents
        if (rd_en) begin
            case (bus.address)
                DISP_DATA_LO: rd_d = lo_q;
                DISP_DATA_HI: rd_d = hi_q;
                DISP_CTRL:    rd_d = {dp_q, en_q};
                default:      rd_d = 16'h0000;
            endcase
        end

        if (wr_en) begin
            case (bus.address)
                DISP_DATA_LO: lo_d = bus.write_data_input;
                DISP_DATA_HI: hi_d = bus.write_data_input;
                DISP_CTRL: begin
                    en_d = bus.write_data_input[7:0];
                    dp_d = bus.write_data_input[15:8];
                end
                default: ;
            endcase
        end

        if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        state_d = (cnt_d < CW'(BLANK_CYC)) ? ST_BLANK : ST_SHOW;

        if (state_q == ST_SHOW && en_q[idx_q]) begin
            seg_d = {~dp_q[idx_q], ~pat};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lo_q    <= 16'h0000;
            hi_q    <= 16'h0000;
            en_q    <= 8'h00;
            dp_q    <= 8'h00;
            rd_q    <= 16'h0000;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            state_q <= ST_BLANK;
            seg_q   <= SEG_OFF;
            dsel_q  <= 8'hFF;
        end else begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            en_q    <= en_d;
            dp_q    <= dp_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            seg_q   <= seg_d;
            dsel_q  <= dsel_d;
        end
    end

    assign seg                  = seg_q;
    assign digit_sel            = dsel_q;
    assign bus.read_data_output = rd_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboarded bench for seg_display_ctrl: a behavioural model predicts every output cycle.
module tb_seg_display_ctrl;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;

    typedef struct packed {
        logic [7:0]  seg;
        logic [7:0]  dsel;
        logic [15:0] rd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg, digit_sel;

    seg_display_ctrl_if bus ();

    seg_display_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clock     (clk),
        .reset     (rst),
        .bus       (bus),
        .seg       (seg),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [6:0] pat_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [15:0] m_lo, m_hi, m_ctrl;
    int          m_cnt, m_idx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Predict the next edge from current inputs and model state, then advance both
    task automatic cycle();
        exp_t        e;
        logic [3:0]  nib;
        logic [15:0] rv;
        if (rst) begin
            e = '{seg: 8'hFF, dsel: 8'hFF, rd: 16'h0000};
            m_lo = 16'h0; m_hi = 16'h0; m_ctrl = 16'h0;
            m_cnt = 0; m_idx = 0;
        end else begin
            e.dsel = ~(8'h01 << m_idx);
            nib = (m_idx < 4) ? m_lo[m_idx*4 +: 4] : m_hi[(m_idx-4)*4 +: 4];
            if (m_cnt < BLANK_CYC || !m_ctrl[m_idx]) e.seg = 8'hFF;
            else e.seg = {~m_ctrl[8+m_idx], ~pat_tbl[nib]};
            rv = 16'h0000;
            if (bus.displayCtrl && bus.read_enable) begin
                case (bus.address)
                    3'b000: rv = m_lo;
                    3'b010: rv = m_hi;
                    3'b100: rv = m_ctrl;
                    default: rv = 16'h0000;
                endcase
            end
            e.rd = rv;
            if (bus.displayCtrl && bus.write_enable) begin
                case (bus.address)
                    3'b000: m_lo = bus.write_data_input;
                    3'b010: m_hi = bus.write_data_input;
                    3'b100: m_ctrl = bus.write_data_input;
                    default: ;
                endcase
            end
            m_cnt = m_cnt + 1;
            if (m_cnt == SCAN_DIV) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("seg", seg, e.seg);
        check_eq("digit_sel", digit_sel, e.dsel);
        check_eq("read_data", bus.read_data_output, e.rd);
        if (!rst) check_eq("onehot", $countones(~digit_sel), 1);
        @(negedge clk);
    endtask

    task automatic bus_idle();
        bus.displayCtrl      = 1'b0;
        bus.write_enable     = 1'b0;
        bus.read_enable      = 1'b0;
        bus.address          = 3'b000;
        bus.write_data_input = 16'h0000;
    endtask

    task automatic bus_access(input logic we, input logic re, input logic [2:0] addr,
                              input logic [15:0] data);
        bus.displayCtrl      = 1'b1;
        bus.write_enable     = we;
        bus.read_enable      = re;
        bus.address          = addr;
        bus.write_data_input = data;
        cycle();
        bus_idle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit found;
        bus_idle();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(13);

        // 1: reset mid-scan
        rst = 1'b1;
        run(3);
        check_eq("rst_seg", seg, 8'hFF);
        check_eq("rst_dsel", digit_sel, 8'hFF);
        check_eq("rst_rd", bus.read_data_output, 16'h0000);
        rst = 1'b0;
        run(1);
        check_eq("post_rst_dsel", digit_sel, 8'hFE);

        // 2: low digits only
        bus_access(1'b1, 1'b0, 3'b000, 16'h1234);
        bus_access(1'b1, 1'b0, 3'b100, 16'h000F);
        run(8 * SCAN_DIV);

        // 3: all digits, dp on digit 0, wrap 7->0
        bus_access(1'b1, 1'b0, 3'b100, 16'h01FF);
        bus_access(1'b1, 1'b0, 3'b010, 16'hABCD);
        run(8 * SCAN_DIV + 4);

        // 4: write during digit 0 SHOW shows on the following cycle
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_idx == 0 && m_cnt == BLANK_CYC) found = 1'b1;
            else cycle();
        end
        check_eq("t4_found", {31'b0, found}, 32'd1);
        bus_access(1'b1, 1'b0, 3'b000, 16'h0007);
        cycle();
        check_eq("t4_seg", seg, 8'h78);

        // 5: read-back and unmapped offsets
        bus_access(1'b1, 1'b0, 3'b000, 16'hBEEF);
        bus_access(1'b0, 1'b1, 3'b000, 16'h0000);
        check_eq("rd_lo", bus.read_data_output, 16'hBEEF);
        bus_access(1'b0, 1'b1, 3'b110, 16'h0000);
        check_eq("rd_unmapped", bus.read_data_output, 16'h0000);
        bus_access(1'b1, 1'b0, 3'b110, 16'hFFFF);
        bus_access(1'b0, 1'b1, 3'b000, 16'h0000);
        check_eq("rd_lo_kept", bus.read_data_output, 16'hBEEF);
        bus_access(1'b0, 1'b1, 3'b010, 16'h0000);
        check_eq("rd_hi_kept", bus.read_data_output, 16'hABCD);
        bus_access(1'b0, 1'b1, 3'b100, 16'h0000);
        check_eq("rd_ctrl_kept", bus.read_data_output, 16'h01FF);
        cycle();
        check_eq("rd_idle", bus.read_data_output, 16'h0000);

        // 6: simultaneous read+write returns old value
        bus_access(1'b1, 1'b0, 3'b010, 16'h1111);
        bus_access(1'b1, 1'b1, 3'b010, 16'h2222);
        check_eq("rw_old", bus.read_data_output, 16'h1111);
        bus_access(1'b0, 1'b1, 3'b010, 16'h0000);
        check_eq("rw_new", bus.read_data_output, 16'h2222);
        run(3 * 8 * SCAN_DIV);

        if (sb_q.size() != 0) check_eq("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
